// File: rtl/nn_pkg.sv
// Shared constants and state type for the NN inference result path.
package nn_pkg;

    localparam int dataWidth  = 16;
    localparam int numNeurons = 10;
    localparam int OUT_WIDTH  = 32;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/nn_argmax_step.sv
// One argmax step: signed compare-and-select; the incumbent wins ties.
module nn_argmax_step
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = dataWidth,
    parameter int IDX_WIDTH  = 4
) (
    input  logic [DATA_WIDTH-1:0] cur_val_i,
    input  logic [IDX_WIDTH-1:0]  cur_idx_i,
    input  logic [DATA_WIDTH-1:0] new_val_i,
    input  logic [IDX_WIDTH-1:0]  new_idx_i,
    output logic [DATA_WIDTH-1:0] sel_val_o,
    output logic [IDX_WIDTH-1:0]  sel_idx_o
);

    always_comb begin
        if ($signed(new_val_i) > $signed(cur_val_i)) begin
            sel_val_o = new_val_i;
            sel_idx_o = new_idx_i;
        end else begin
            sel_val_o = cur_val_i;
            sel_idx_o = cur_idx_i;
        end
    end

endmodule

// File: rtl/nn_result_responder.sv
// Captures the final-layer output vector, runs a sequential argmax (one element
// per clock) and returns the winning index to the host with a level interrupt.
module nn_result_responder
    import nn_pkg::*;
#(
    parameter int NUM_INPUT  = numNeurons,
    parameter int DATA_WIDTH = dataWidth,
    parameter int OUT_WIDTH  = nn_pkg::OUT_WIDTH
) (
    input  logic                            aclk,
    input  logic                            reset,
    input  logic                            x_valid,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] x_in,
    input  logic                            intr_clr,
    output logic [OUT_WIDTH-1:0]            rdata,
    output logic                            o_valid,
    output logic                            intr,
    output logic                            overrun
);

    localparam int CNT_W = $clog2(NUM_INPUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUT - 1);

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  buf_q [NUM_INPUT];
    logic [DATA_WIDTH-1:0]  buf_d [NUM_INPUT];
    logic [DATA_WIDTH-1:0]  max_val_q, max_val_d;
    logic [CNT_W-1:0]       max_idx_q, max_idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   o_valid_q, o_valid_d;
    logic                   intr_q, intr_d;
    logic                   overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0]  cur_elem;
    logic [DATA_WIDTH-1:0]  step_val;
    logic [CNT_W-1:0]       step_idx;
    logic                   publish;
    logic [CNT_W-1:0]       pub_idx;

    always_comb begin
        cur_elem = '0;
        for (int unsigned i = 0; i < NUM_INPUT; i++) begin
            if (cnt_q == CNT_W'(i)) cur_elem = buf_q[i];
        end
    end

    nn_argmax_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (CNT_W)
    ) u_step (
        .cur_val_i  (max_val_q),
        .cur_idx_i  (max_idx_q),
        .new_val_i  (cur_elem),
        .new_idx_i  (cnt_q),
        .sel_val_o  (step_val),
        .sel_idx_o  (step_idx)
    );

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        o_valid_d = 1'b0;
        intr_d    = intr_q;
        overrun_d = 1'b0;
        publish   = 1'b0;
        pub_idx   = '0;

        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    for (int unsigned i = 0; i < NUM_INPUT; i++) begin
                        buf_d[i] = x_in[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    max_val_d = x_in[DATA_WIDTH-1:0];
                    max_idx_d = '0;
                    cnt_d     = CNT_W'(1);
                    // A single-element vector has nothing to scan.
                    if (NUM_INPUT == 1) publish = 1'b1;
                    else                state_d = SCAN;
                end
            end
            SCAN: begin
                max_val_d = step_val;
                max_idx_d = step_idx;
                cnt_d     = cnt_q + CNT_W'(1);
                overrun_d = x_valid;
                if (cnt_q == LAST) begin
                    publish = 1'b1;
                    pub_idx = step_idx;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Publishing has priority over a same-cycle host acknowledge.
        if (publish) begin
            rdata_d   = OUT_WIDTH'(pub_idx);
            o_valid_d = 1'b1;
            intr_d    = 1'b1;
        end else if (intr_clr) begin
            intr_d    = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int unsigned i = 0; i < NUM_INPUT; i++) buf_q[i] <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            o_valid_q <= 1'b0;
            intr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            o_valid_q <= o_valid_d;
            intr_q    <= intr_d;
            overrun_q <= overrun_d;
        end
    end

    assign rdata   = rdata_q;
    assign o_valid = o_valid_q;
    assign intr    = intr_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_nn_result_responder.sv
// Directed and random checks of nn_result_responder against a plain argmax model.
module tb_nn_result_responder;
    import nn_pkg::*;

    localparam int N  = numNeurons;
    localparam int DW = dataWidth;
    localparam int OW = nn_pkg::OUT_WIDTH;

    logic            aclk = 1'b0;
    logic            reset;
    logic            x_valid;
    logic [N*DW-1:0] x_in;
    logic            intr_clr;
    logic [OW-1:0]   rdata;
    logic            o_valid;
    logic            intr;
    logic            overrun;

    int n_vec  = 0;
    int n_miss = 0;
    int e [N];

    always #5 aclk = ~aclk;

    nn_result_responder #(
        .NUM_INPUT  (N),
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW)
    ) dut (
        .aclk     (aclk),
        .reset    (reset),
        .x_valid  (x_valid),
        .x_in     (x_in),
        .intr_clr (intr_clr),
        .rdata    (rdata),
        .o_valid  (o_valid),
        .intr     (intr),
        .overrun  (overrun)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] mkvec();
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(e[i]);
        return v;
    endfunction

    // First index holding the largest signed value.
    function automatic int ref_argmax();
        int best;
        best = 0;
        for (int i = 1; i < N; i++) if (e[i] > e[best]) best = i;
        return best;
    endfunction

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) e[i] = v;
    endtask

    task automatic send();
        x_in    = mkvec();
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
    endtask

    // Called one cycle after capture; ends in the publish cycle.
    task automatic expect_result(input int exp, input string tag);
        repeat (N - 2) tick();
        check({tag, "_early"}, 32'(o_valid), 32'd0);
        tick();
        check({tag, "_ovalid"}, 32'(o_valid), 32'd1);
        check({tag, "_rdata"}, rdata, 32'(exp));
        check({tag, "_intr"}, 32'(intr), 32'd1);
    endtask

    initial begin
        int exp1;
        int bad;

        reset    = 1'b1;
        x_valid  = 1'b0;
        intr_clr = 1'b0;
        x_in     = '0;
        repeat (3) tick();
        check("rst_rdata", rdata, 32'd0);
        check("rst_ovalid", 32'(o_valid), 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        fill(0); e[9] = 100; e[3] = 500;
        send();
        expect_result(ref_argmax(), "basic");
        tick();
        check("basic_pulse", 32'(o_valid), 32'd0);
        repeat (2) tick();
        check("intr_hold", 32'(intr), 32'd1);
        intr_clr = 1'b1;
        tick();
        intr_clr = 1'b0;
        check("intr_clr", 32'(intr), 32'd0);
        check("rdata_keep", rdata, 32'd3);

        fill(-5); e[7] = -1;
        send();
        expect_result(ref_argmax(), "neg");
        fill(-32768);
        send();
        expect_result(ref_argmax(), "allmin");
        fill(-32768); e[5] = -32767;
        send();
        expect_result(ref_argmax(), "min_vs");
        fill(0); e[2] = 1024; e[8] = 1024;
        send();
        expect_result(ref_argmax(), "tie");
        fill(0); e[9] = 1;
        send();
        expect_result(ref_argmax(), "last");

        fill(0); e[6] = 1000;
        exp1 = ref_argmax();
        send();
        repeat (3) tick();
        fill(0); e[1] = 2000;
        x_in    = mkvec();
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        check("overrun_pulse", 32'(overrun), 32'd1);
        tick();
        check("overrun_end", 32'(overrun), 32'd0);
        repeat (3) tick();
        check("ovr_early", 32'(o_valid), 32'd0);
        tick();
        check("ovr_ovalid", 32'(o_valid), 32'd1);
        check("ovr_rdata", rdata, 32'(exp1));
        send();
        expect_result(ref_argmax(), "b2b");

        intr_clr = 1'b1;
        tick();
        intr_clr = 1'b0;
        fill(0); e[4] = 77;
        send();
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bad = 0;
        repeat (N + 2) begin
            if (o_valid || intr) bad++;
            tick();
        end
        check("rst_mid_quiet", 32'(bad), 32'd0);
        fill(0); e[8] = 300; e[0] = -300;
        send();
        expect_result(ref_argmax(), "post_rst");

        intr_clr = 1'b1;
        tick();
        intr_clr = 1'b0;
        check("clr_pre", 32'(intr), 32'd0);
        fill(10); e[4] = 11;
        send();
        repeat (N - 2) tick();
        intr_clr = 1'b1;
        tick();
        intr_clr = 1'b0;
        check("setclr_ovalid", 32'(o_valid), 32'd1);
        check("setclr_rdata", rdata, 32'(ref_argmax()));
        check("setclr_intr", 32'(intr), 32'd1);
        tick();
        check("setclr_intr2", 32'(intr), 32'd1);

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < N; i++) begin
                if (f % 3 == 0) e[i] = int'($urandom_range(8)) - 4;
                else            e[i] = int'($urandom_range(65535)) - 32768;
            end
            send();
            expect_result(ref_argmax(), $sformatf("rand%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
